// File: rtl/mole_box_picker_if.sv
// Request/response channel between the game-control FSM (master) and the box picker (slave).
interface mole_box_picker_if #(
   parameter int unsigned BOX_W = 2
);
   logic             req;
   logic             busy;
   logic             valid;
   logic [BOX_W-1:0] box;

   modport master (output req, input busy, valid, box);
   modport slave  (input req, output busy, valid, box);
endinterface

// File: rtl/mole_box_picker.sv
// Free-running Fibonacci LFSR plus a rejection-sampling search that hands out
// uniformly distributed box indices, optionally never repeating the previous box.
module mole_box_picker #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
   parameter int unsigned      NUM_BOXES = 4,
   parameter int unsigned      BOX_W     = 2,
   parameter bit               NO_REPEAT = 1'b1,
   parameter int unsigned      MAX_TRIES = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              seed_load,
   input  logic [WIDTH-1:0]  seed,
   mole_box_picker_if.slave  bus,
   output logic [WIDTH-1:0]  lfsr_state
);
   localparam int unsigned TW = $clog2(MAX_TRIES) + 1;

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] lfsr;
   logic [TW-1:0]    tries, tries_nx;
   logic [BOX_W-1:0] box, box_nx, cand, box_inc;
   logic             valid, valid_nx;
   logic             have_last, have_last_nx;
   logic             accept;

   // The LFSR never stalls; a zero seed would lock it up, so it becomes 1.
   always_ff @(posedge clk) begin
      if (!resetn)        lfsr <= WIDTH'(1);
      else if (seed_load) lfsr <= (seed == '0) ? WIDTH'(1) : seed;
      else                lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
   end

   assign cand    = lfsr[BOX_W-1:0];
   assign accept  = (32'(cand) < NUM_BOXES) && !(NO_REPEAT && have_last && (cand == box));
   assign box_inc = (32'(box) >= NUM_BOXES - 1) ? '0 : box + BOX_W'(1);

   always_comb begin
      state_nx     = state;
      tries_nx     = tries;
      box_nx       = box;
      valid_nx     = 1'b0;
      have_last_nx = have_last;
      case (state)
         IDLE: begin
            if (bus.req) begin
               state_nx = SEARCH;
               tries_nx = '0;
            end
         end
         SEARCH: begin
            if (accept) begin
               box_nx       = cand;
               valid_nx     = 1'b1;
               have_last_nx = 1'b1;
               state_nx     = IDLE;
            end else if (tries == TW'(MAX_TRIES - 1)) begin
               // Search budget exhausted: step deterministically so the game never stalls.
               box_nx       = have_last ? box_inc : '0;
               valid_nx     = 1'b1;
               have_last_nx = 1'b1;
               state_nx     = IDLE;
            end else begin
               tries_nx = tries + TW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         tries     <= '0;
         box       <= '0;
         valid     <= 1'b0;
         have_last <= 1'b0;
      end else begin
         state     <= state_nx;
         tries     <= tries_nx;
         box       <= box_nx;
         valid     <= valid_nx;
         have_last <= have_last_nx;
      end
   end

   assign bus.busy   = (state == SEARCH);
   assign bus.valid  = valid;
   assign bus.box    = box;
   assign lfsr_state = lfsr;
endmodule

// File: tb/tb_mole_box_picker.sv
// Bench for mole_box_picker: three configurations share one clock, reset and seed bus;
// picks are predicted from the LFSR sequence and the acceptance rules.
module tb_mole_box_picker;
   logic       clk = 1'b0;
   logic       resetn;
   logic       seed_load;
   logic [7:0] seed;
   logic [7:0] lf_a, lf_b, lf_c;
   logic [7:0] m_lfsr;
   int         n_chk = 0;
   int         n_fail = 0;

   mole_box_picker_if #(.BOX_W(2)) a_if ();
   mole_box_picker_if #(.BOX_W(2)) b_if ();
   mole_box_picker_if #(.BOX_W(2)) c_if ();

   mole_box_picker #(.NUM_BOXES(4), .NO_REPEAT(1'b0)) dut_a (
      .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed(seed), .bus(a_if), .lfsr_state(lf_a));
   mole_box_picker #(.NUM_BOXES(4), .NO_REPEAT(1'b1)) dut_b (
      .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed(seed), .bus(b_if), .lfsr_state(lf_b));
   mole_box_picker #(.NUM_BOXES(1), .NO_REPEAT(1'b1), .MAX_TRIES(16)) dut_c (
      .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed(seed), .bus(c_if), .lfsr_state(lf_c));

   always #5 clk = ~clk;

   // Polynomial x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3.
   function automatic logic [7:0] lf_next(input logic [7:0] x);
      logic fb;
      fb = x[7] ^ x[5] ^ x[4] ^ x[3];
      return {x[6:0], fb};
   endfunction

   always @(posedge clk) begin
      if (!resetn)        m_lfsr <= 8'h01;
      else if (seed_load) m_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
      else                m_lfsr <= lf_next(m_lfsr);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Walk the future LFSR values and apply the acceptance rules directly.
   task automatic predict(input logic [7:0] v0, input int nb, input bit nr, input bit hl,
                          input logic [1:0] last, input int mt, output int k, output logic [1:0] b);
      logic [7:0] v;
      v = v0;
      for (int i = 0; i < mt; i++) begin
         if (int'(v[1:0]) < nb && !(nr && hl && v[1:0] == last)) begin
            k = i; b = v[1:0];
            return;
         end
         v = lf_next(v);
      end
      k = mt - 1;
      b = hl ? 2'((int'(last) + 1) % nb) : 2'd0;
   endtask

   task automatic set_req(input int w, input logic v);
      case (w)
         0:       a_if.req = v;
         1:       b_if.req = v;
         default: c_if.req = v;
      endcase
   endtask

   function automatic logic get_valid(input int w);
      case (w)
         0:       return a_if.valid;
         1:       return b_if.valid;
         default: return c_if.valid;
      endcase
   endfunction

   function automatic logic [1:0] get_box(input int w);
      case (w)
         0:       return a_if.box;
         1:       return b_if.box;
         default: return c_if.box;
      endcase
   endfunction

   task automatic run_pick(input int w, input int nb, input bit nr, inout bit hl, inout logic [1:0] last);
      int         k, n;
      logic [1:0] b;
      bit         got;
      set_req(w, 1'b1);
      @(negedge clk);
      set_req(w, 1'b0);
      predict(m_lfsr, nb, nr, hl, last, 16, k, b);
      n = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (get_valid(w)) got = 1;
      end
      chk("pick_latency", n, k + 1);
      chk("pick_box", get_box(w), b);
      hl = 1; last = b;
   endtask

   typedef struct {
      logic       sl;
      logic [7:0] sd;
      logic [7:0] exp;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[10];
      bit         seen[256];
      int         ret, dup, zero, nv, nbusy, picks, rep, cyc;
      int         cnt[4];
      bit         got, hl_a, hl_b;
      logic [1:0] last_a, last_b, prev;

      tbl = '{'{1'b0, 8'h00, 8'h02}, '{1'b0, 8'h00, 8'h04}, '{1'b0, 8'h00, 8'h08},
              '{1'b0, 8'h00, 8'h11}, '{1'b0, 8'h00, 8'h23}, '{1'b0, 8'h00, 8'h47},
              '{1'b0, 8'h00, 8'h8E}, '{1'b1, 8'h00, 8'h01}, '{1'b1, 8'h47, 8'h47},
              '{1'b0, 8'h00, 8'h8E}};

      resetn = 1'b0; seed_load = 1'b0; seed = 8'h00;
      a_if.req = 1'b0; b_if.req = 1'b0; c_if.req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      chk("rst_lfsr_a", lf_a, 8'h01);
      chk("rst_lfsr_c", lf_c, 8'h01);
      chk("rst_box_a", a_if.box, 0);
      chk("rst_valid_a", a_if.valid, 0);
      chk("rst_busy_a", a_if.busy, 0);
      chk("rst_box_b", b_if.box, 0);
      chk("rst_valid_b", b_if.valid, 0);
      chk("rst_busy_c", c_if.busy, 0);

      // Free-run sequence, then zero-seed substitution and a normal seed load.
      for (int i = 0; i < 10; i++) begin
         seed_load = tbl[i].sl; seed = tbl[i].sd;
         @(negedge clk);
         seed_load = 1'b0;
         chk($sformatf("seq_row%0d", i), lf_a, tbl[i].exp);
      end

      // Full period from 0x01.
      seed_load = 1'b1; seed = 8'h01;
      @(negedge clk);
      seed_load = 1'b0;
      for (int i = 0; i < 256; i++) seen[i] = 0;
      seen[1] = 1; ret = 0; dup = 0; zero = 0;
      for (int k = 1; k <= 300 && ret == 0; k++) begin
         @(negedge clk);
         nv = int'(lf_a);
         if (nv == 0) zero = 1;
         if (nv == 1) ret = k;
         else begin
            if (seen[nv]) dup++;
            seen[nv] = 1;
         end
      end
      chk("period", ret, 255);
      chk("period_dup", dup, 0);
      chk("period_zero", zero, 0);

      // Handshake on dut_a: seed 0x47, req held through the busy cycle is ignored.
      seed_load = 1'b1; seed = 8'h47;
      @(negedge clk);
      seed_load = 1'b0; a_if.req = 1'b1;
      @(negedge clk);
      chk("hs_busy", a_if.busy, 1);
      chk("hs_valid_early", a_if.valid, 0);
      @(negedge clk);
      a_if.req = 1'b0;
      chk("hs_valid", a_if.valid, 1);
      chk("hs_box", a_if.box, 2);
      nv = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_if.valid) nv++;
      end
      chk("hs_one_pulse", nv, 1);

      // Randomized picks on both multi-box configurations.
      hl_a = 0; hl_b = 0; last_a = 0; last_b = 0;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            seed_load = 1'b1; seed = 8'($urandom_range(0, 255));
            @(negedge clk);
            seed_load = 1'b0;
         end
         repeat ($urandom_range(0, 4)) @(negedge clk);
         chk("lfsr_track", lf_b, m_lfsr);
         if (t % 2 == 0) run_pick(0, 4, 1'b0, hl_a, last_a);
         else            run_pick(1, 4, 1'b1, hl_b, last_b);
      end

      // Held request on the no-repeat configuration.
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      picks = 0; rep = 0; cyc = 0; prev = 0;
      b_if.req = 1'b1;
      while (picks < 1000 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (b_if.valid) begin
            if (picks > 0 && b_if.box == prev) rep++;
            cnt[b_if.box]++;
            prev = b_if.box;
            picks++;
         end
      end
      b_if.req = 1'b0;
      chk("held_picks", picks, 1000);
      chk("held_repeats", rep, 0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("held_count_in_range_box%0d", i), (cnt[i] >= 190 && cnt[i] <= 310), 1);

      // Single box: first pick accepts at once, second runs into the fallback.
      @(negedge clk);
      seed_load = 1'b1; seed = 8'h04; c_if.req = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; c_if.req = 1'b0;
      chk("fb_first_busy", c_if.busy, 1);
      @(negedge clk);
      chk("fb_first_valid", c_if.valid, 1);
      chk("fb_first_box", c_if.box, 0);
      c_if.req = 1'b1;
      @(negedge clk);
      c_if.req = 1'b0;
      nbusy = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (c_if.valid) got = 1;
         else if (c_if.busy) nbusy++;
         // A seed load mid-search must not disturb the FSM.
         seed_load = (nbusy == 5) ? 1'b1 : 1'b0;
         seed = 8'h5A;
         if (!got) @(negedge clk);
      end
      seed_load = 1'b0;
      chk("fb_busy_cycles", nbusy, 16);
      chk("fb_valid", got, 1);
      chk("fb_box", c_if.box, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mole_box_picker.md
Name: mole_box_picker

Overview:
- Parametrised successor to the 3-bit free-running mole-position LFSR.
- Provides a WIDTH-bit maximal-length Fibonacci LFSR with a configurable tap mask and a runtime seed load.
- Serves a req/valid handshake that returns a box index uniformly distributed over NUM_BOXES, using rejection sampling in place of the old non-uniform state-to-box mapping.
- Has an optional no-repeat mode so the mole never appears in the same box twice in a row. Sits between the game-control FSM and the box/VGA drawing logic.

Parameters:
- WIDTH, 8, LFSR width in bits (3..32).
- TAPS, 8'hB8, feedback tap mask; bit i set means out[i] enters the XOR. Default is maximal for WIDTH=8 (x^8+x^6+x^5+x^4+1).
- NUM_BOXES, 4, number of boxes (1..2^BOX_W).
- BOX_W, 2, box index width; candidate is lfsr[BOX_W-1:0].
- NO_REPEAT, 1, 1 rejects a candidate equal to the previous returned box.
- MAX_TRIES, 16, SEARCH cycles before the deterministic fallback is used (>=1).

Ports:
- clk, in, 1, system clock; all logic on posedge.
- resetn, in, 1, synchronous active-low reset.
- seed_load, in, 1, load seed into LFSR this edge.
- seed, in, WIDTH, seed value; 0 is replaced by 1.
- req, in, 1, request a new box; sampled only in IDLE.
- busy, out, 1, high while in SEARCH.
- valid, out, 1, one-cycle pulse; box is valid this cycle.
- box, out, BOX_W, selected box index; holds its value until the next valid.
- lfsr_state, out, WIDTH, current LFSR register (debug / HEX display).

Behaviour:
- Reset (resetn=0 at posedge): lfsr=1, state=IDLE, busy=0, valid=0, box=0, have_last=0, tries=0. Reset overrides everything, including mid-SEARCH.
- LFSR:
  - Shifts every cycle, independent of the FSM: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
  - The all-zero state is unreachable; the seed=0 substitution guarantees this.
  - seed_load has priority over the shift: lfsr <= (seed==0) ? 1 : seed.
  - seed_load does not affect FSM state; an in-progress SEARCH continues on the new sequence.
- FSM states: IDLE, SEARCH.
  - IDLE: valid deasserts after its single cycle. If req=1, go to SEARCH with tries=0. Otherwise stay.
  - SEARCH: at each posedge, evaluate cand = lfsr[BOX_W-1:0] using the pre-shift value.
    - Accept when cand < NUM_BOXES and !(NO_REPEAT && have_last && cand==box).
    - On accept: box<=cand, valid<=1, have_last<=1, go to IDLE.
    - On reject with tries==MAX_TRIES-1: box<=(box+1) mod NUM_BOXES (or 0 if !have_last), valid<=1, have_last<=1, go to IDLE.
    - Otherwise: tries<=tries+1, stay in SEARCH.
- Timing:
  - Latency: req sampled at edge t; the first candidate is evaluated at edge t+1; valid is high in the cycle after edge t+1 at the earliest.
  - Worst case: valid after edge t+MAX_TRIES.
  - busy=1 exactly while state==SEARCH.
- Handshake rules:
  - req while busy is ignored; no queueing.
  - req held high continuously produces back-to-back requests: IDLE spends one cycle (the valid cycle), during which req is sampled again.
- Boundary cases:
  - NUM_BOXES=1 with NO_REPEAT=1: every second-and-later request hits the fallback and returns box 0.
  - NUM_BOXES=2^BOX_W with NO_REPEAT=0: always accepts on the first try.
- Arithmetic: all compares are unsigned. tries is sized to clog2(MAX_TRIES)+1 bits.

Test Plan:
- Reset: hold resetn=0 for 2 cycles, release -> lfsr_state=0x01, box=0, valid=0, busy=0. Free-run sequence is 0x01,0x02,0x04,0x08,0x11,0x23,0x47,0x8E.
- Period: run 255 cycles from seed 0x01 -> state returns to 0x01 exactly at cycle 255, with no earlier repeat and 0x00 never seen.
- Seed: seed_load=1, seed=0x00 -> lfsr_state=0x01 next cycle. seed=0x47 -> 0x47, then 0x8E. Assert seed_load mid-SEARCH -> search continues, valid still arrives.
- Handshake, NUM_BOXES=4, NO_REPEAT=0: seed 0x47, pulse req -> valid one cycle after first SEARCH edge, box = value of lfsr[1:0] at that edge. req during busy is ignored (exactly one valid pulse).
- No-repeat, NUM_BOXES=4, NO_REPEAT=1: hold req high for 1000 picks -> never two consecutive equal boxes. Each box count lies within 250±60.
- Fallback, NUM_BOXES=1, NO_REPEAT=1, MAX_TRIES=16: first req -> box 0 on the first try. Second req -> busy for exactly 16 cycles, then valid with box 0.
